// File: rtl/mul_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM encoding,
// iteration count and operand/product widths.
package mul_pkg;
  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  localparam logic [2:0] ITER_CNT = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/parallel_adder_4bit.sv
// 4-bit ripple-carry adder: sum/cout = a + b + cin, purely combinational.
module parallel_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[4];
endmodule

// File: rtl/shift_add_multiplier_4bit.sv
// Sequential 4x4 unsigned shift-and-add multiplier driving parallel_adder_4bit
// once per RUN cycle. Define MUL_ZERO_SKIP_EN to bypass RUN for zero operands.
module shift_add_multiplier_4bit
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);
  localparam logic [2:0] LAST_CNT = ITER_CNT - 3'd1;

  state_t              r_state;
  state_t              w_next_state;
  logic [OP_W-1:0]     r_m;
  logic [OP_W-1:0]     r_p_hi;
  logic [OP_W-1:0]     r_p_lo;
  logic [2:0]          r_cnt;
  logic [PROD_W-1:0]   r_product;

  logic [OP_W-1:0]     w_addend;
  logic [OP_W-1:0]     w_sum;
  logic                w_cout;
  logic [PROD_W-1:0]   w_shift;
  logic                w_last;

  assign w_addend = r_p_lo[0] ? r_m : '0;

  parallel_adder_4bit u_adder (
    .a    (r_p_hi),
    .b    (w_addend),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // {cout, sum, P_lo} shifted right by one; the adder carry lands in P_hi[3]
  assign w_shift = {w_cout, w_sum, r_p_lo[OP_W-1:1]};
  assign w_last  = (r_cnt == LAST_CNT);

`ifdef MUL_ZERO_SKIP_EN
  logic w_zero;
  assign w_zero = (a == '0) || (b == '0);
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
`ifdef MUL_ZERO_SKIP_EN
          w_next_state = w_zero ? DONE : RUN;
`else
          w_next_state = RUN;
`endif
        end
      end
      RUN:     if (w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_m       <= '0;
      r_p_hi    <= '0;
      r_p_lo    <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_m    <= a;
            r_p_lo <= b;
            r_p_hi <= '0;
            r_cnt  <= '0;
`ifdef MUL_ZERO_SKIP_EN
            if (w_zero) r_product <= '0;
`endif
          end
        end
        RUN: begin
          {r_p_hi, r_p_lo} <= w_shift;
          r_cnt            <= r_cnt + 3'd1;
          if (w_last) r_product <= w_shift;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign product = r_product;
endmodule
